// File: rtl/img_pkg.sv
// Constants, types and compare helpers shared by the median filter and the image chip.
package img_pkg;
    localparam int BIT_LENGTH = 5;
    localparam int IMG_DIM    = 20;
    localparam int CNT_W      = 5;

    typedef logic [BIT_LENGTH-1:0] pix_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    localparam cnt_t LAST_CNT = cnt_t'(IMG_DIM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        pix_t top;
        pix_t mid;
        pix_t bot;
    } column_t;

    typedef struct packed {
        pix_t lo;
        pix_t mid;
        pix_t hi;
    } trio_t;

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
        return min2(min2(a, b), c);
    endfunction

    function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
        return max2(max2(a, b), c);
    endfunction

    // Median of three: the larger of the pair minimum and whatever c leaves of the pair maximum.
    function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction
endpackage

// File: rtl/sort3.sv
// Combinational three-input sorter; one instance per window column in the first sorter stage.
module sort3
    import img_pkg::*;
(
    input  logic [BIT_LENGTH-1:0] a,
    input  logic [BIT_LENGTH-1:0] b,
    input  logic [BIT_LENGTH-1:0] c,
    output logic [BIT_LENGTH-1:0] lo,
    output logic [BIT_LENGTH-1:0] mid,
    output logic [BIT_LENGTH-1:0] hi
);
    assign lo  = min3(a, b, c);
    assign mid = med3(a, b, c);
    assign hi  = max3(a, b, c);
endmodule

// File: rtl/median_window_filter.sv
// 3x3 median engine: sliding 3-column window feeding a 3-stage sorter, with a single global stall.
module median_window_filter
    import img_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIT_LENGTH-1:0] in0,
    input  logic [BIT_LENGTH-1:0] in1,
    input  logic [BIT_LENGTH-1:0] in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIT_LENGTH-1:0] med_out,
    output logic                  out_last,
    output logic                  busy
);
    state_t          state;
    cnt_t            col_cnt;
    column_t [2:0]   win;        // win[0] is the newest column
    logic            win_valid, win_last;
    trio_t   [2:0]   srt;
    trio_t   [2:0]   s1_col;
    logic            s1_valid, s1_last;
    pix_t            s2_a, s2_b, s2_c;
    logic            s2_valid, s2_last;
    pix_t            s3_med;
    logic            s3_valid, s3_last;
    logic            en, accept;

    // Whole datapath advances together; a held output freezes every stage behind it.
    assign en       = !s3_valid || out_ready;
    assign in_ready = en && (state == FILL || state == RUN);
    assign accept   = in_valid && in_ready;

    for (genvar g = 0; g < 3; g++) begin : g_col_sort
        sort3 u_sort3 (
            .a   (win[g].top),
            .b   (win[g].mid),
            .c   (win[g].bot),
            .lo  (srt[g].lo),
            .mid (srt[g].mid),
            .hi  (srt[g].hi)
        );
    end

    // NOTE: state is written with <= only, so every reader sees the pre-edge value regardless of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            col_cnt   <= '0;
            // NOTE: the window is a handful of flops, not a RAM, so it is cleared so no stale pixels survive a reset.
            win       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= FILL;
                    col_cnt <= '0;
                end
                FILL:  if (accept && col_cnt == cnt_t'(1)) state <= RUN;
                RUN:   if (accept && col_cnt == LAST_CNT)  state <= DRAIN;
                DRAIN: if (!(win_valid || s1_valid || s2_valid || s3_valid)) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (accept) begin
                col_cnt <= col_cnt + 1'b1;
                win[2]  <= win[1];
                win[1]  <= win[0];
                win[0]  <= '{top: in0, mid: in1, bot: in2};
            end

            if (en) begin
                win_valid <= accept && (state == RUN);
                win_last  <= accept && (state == RUN) && (col_cnt == LAST_CNT);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_col   <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_a     <= '0;
            s2_b     <= '0;
            s2_c     <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s3_med   <= '0;
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
        end else if (en) begin
            s1_col   <= srt;
            s1_valid <= win_valid;
            s1_last  <= win_last;

            // Largest low, median middle, smallest high: the window median is the median of these three.
            s2_a     <= max3(s1_col[0].lo,  s1_col[1].lo,  s1_col[2].lo);
            s2_b     <= med3(s1_col[0].mid, s1_col[1].mid, s1_col[2].mid);
            s2_c     <= min3(s1_col[0].hi,  s1_col[1].hi,  s1_col[2].hi);
            s2_valid <= s1_valid;
            s2_last  <= s1_last;

            s3_med   <= med3(s2_a, s2_b, s2_c);
            s3_valid <= s2_valid;
            s3_last  <= s2_last;
        end
    end

    assign out_valid = s3_valid;
    assign med_out   = s3_med;
    assign out_last  = s3_last;
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_median_window_filter.sv
// Scoreboard bench: the driver pushes reference medians on every accepted column, a monitor pops on each output handshake.
module tb_median_window_filter;
    import img_pkg::*;

    localparam int NOUT = IMG_DIM - 2;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  start = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [BIT_LENGTH-1:0] in0 = '0, in1 = '0, in2 = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [BIT_LENGTH-1:0] med_out;
    logic                  out_last;
    logic                  busy;

    median_window_filter dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .med_out   (med_out),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: keep the last three accepted columns, sort all nine pixels, take the middle one.
    logic [BIT_LENGTH:0]     exp_q[$];
    logic [3*BIT_LENGTH-1:0] model_win[$];
    int acc_cnt   = 0;
    int acc3_cyc  = 0;

    function automatic int model_median();
        int vals[$];
        foreach (model_win[i]) begin
            vals.push_back(int'(model_win[i][3*BIT_LENGTH-1:2*BIT_LENGTH]));
            vals.push_back(int'(model_win[i][2*BIT_LENGTH-1:BIT_LENGTH]));
            vals.push_back(int'(model_win[i][BIT_LENGTH-1:0]));
        end
        vals.sort();
        return vals[4];
    endfunction

    task automatic model_accept(input logic [BIT_LENGTH-1:0] a, b, c);
        int m;
        acc_cnt++;
        model_win.push_back({a, b, c});
        if (model_win.size() > 3) void'(model_win.pop_front());
        if (acc_cnt == 3) acc3_cyc = cyc;
        if (acc_cnt >= 3) begin
            m = model_median();
            exp_q.push_back({(acc_cnt == IMG_DIM), BIT_LENGTH'(m)});
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        model_win.delete();
        acc_cnt = 0;
    endtask

    // Output-ready driver: scripted stall window, random backpressure, or always ready.
    int stall_left = 0;
    bit rand_ready = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else if (rand_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor: compare on every handshake and verify that a refused output holds still.
    int  sweep_pops = 0;
    bit  lat_check  = 0;
    bit  held = 0;
    logic [BIT_LENGTH-1:0] held_med;
    logic                  held_last;
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            held = 0;
        end else begin
            if (held) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_med",   32'(med_out),   32'(held_med));
                check("hold_last",  32'(out_last),  32'(held_last));
            end
            held = 0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got med %0d, expected none (cycle %0d)", med_out, cyc);
                    end else begin
                        logic [BIT_LENGTH:0] e;
                        e = exp_q.pop_front();
                        if (sweep_pops == 0 && lat_check)
                            check("first_latency", 32'(cyc - acc3_cyc), 32'd4);
                        check("med_out",  32'(med_out),  32'(e[BIT_LENGTH-1:0]));
                        check("out_last", 32'(out_last), 32'(e[BIT_LENGTH]));
                    end
                    sweep_pops++;
                end else begin
                    held      = 1;
                    held_med  = med_out;
                    held_last = out_last;
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                end
            end
        end
    end

    logic [BIT_LENGTH-1:0] c0[IMG_DIM], c1[IMG_DIM], c2[IMG_DIM];

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_col(input logic [BIT_LENGTH-1:0] a, b, c, input bit gaps);
        bit done = 0;
        if (gaps) repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in0 = a;
        in1 = b;
        in2 = c;
        for (int w = 0; w < 200 && !done; w++) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(a, b, c);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in0 = BIT_LENGTH'($urandom);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready low for 200 cycles, expected acceptance");
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!busy && exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("idle_after_sweep", 32'(busy), 32'd0);
        check("queue_drained",    32'(exp_q.size()), 32'd0);
    endtask

    // One sweep of the column tables; stall_at/start_at name the column after which to stall or pulse start.
    task automatic do_sweep(input bit gaps, input bit rnd, input int stall_at, input int start_at, input bit lat);
        rand_ready = rnd;
        lat_check  = lat;
        sweep_pops = 0;
        model_clear();
        check("idle_before_start", 32'(busy), 32'd0);
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        for (int k = 0; k < IMG_DIM; k++) begin
            send_col(c0[k], c1[k], c2[k], gaps);
            if (k == stall_at) stall_left = 5;
            if (k == start_at) pulse_start();
        end
        wait_idle();
        check("sweep_outputs", 32'(sweep_pops), 32'(NOUT));
        rand_ready = 0;
        lat_check  = 0;
    endtask

    task automatic load_ramp();
        for (int k = 0; k < IMG_DIM; k++) begin
            c0[k] = BIT_LENGTH'(k);
            c1[k] = BIT_LENGTH'(k);
            c2[k] = BIT_LENGTH'(k);
        end
    endtask

    task automatic load_random();
        for (int k = 0; k < IMG_DIM; k++) begin
            c0[k] = BIT_LENGTH'($urandom);
            c1[k] = BIT_LENGTH'($urandom);
            c2[k] = BIT_LENGTH'($urandom);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_med_out"},   32'(med_out),   32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        #3;
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Ramp with no stalls: medians 1..18, first one four sampled cycles after the third accept.
        load_ramp();
        do_sweep(0, 0, -1, -1, 1);

        // Single bright pixel never survives the median.
        for (int k = 0; k < IMG_DIM; k++) begin
            c0[k] = '0;
            c1[k] = '0;
            c2[k] = '0;
        end
        c1[7] = BIT_LENGTH'(31);
        do_sweep(1, 1, -1, -1, 0);

        // Saturated opening window (median 31) followed by an all-zero column, then random fill.
        load_random();
        c0[0] = 5'd31; c1[0] = 5'd0;  c2[0] = 5'd31;
        c0[1] = 5'd0;  c1[1] = 5'd31; c2[1] = 5'd0;
        c0[2] = 5'd31; c1[2] = 5'd31; c2[2] = 5'd0;
        c0[3] = 5'd0;  c1[3] = 5'd0;  c2[3] = 5'd0;
        do_sweep(0, 0, -1, -1, 0);

        // Five-cycle output stall in the middle of RUN.
        load_ramp();
        do_sweep(0, 0, 8, -1, 0);

        // Start pulses while RUN and while DRAIN must be ignored.
        load_random();
        do_sweep(0, 0, -1, 6, 0);
        load_random();
        do_sweep(1, 1, -1, IMG_DIM - 1, 0);

        // Asynchronous reset after ten columns, then a clean ramp sweep.
        load_ramp();
        model_clear();
        pulse_start();
        for (int k = 0; k < 10; k++) send_col(c0[k], c1[k], c2[k], 0);
        #2;
        reset = 1'b0;
        #1;
        check_outputs_zero("midrun_reset");
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_sweep(0, 0, -1, -1, 1);

        // Random data under random backpressure and input gaps.
        for (int r = 0; r < 3; r++) begin
            load_random();
            do_sweep(1, 1, -1, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
